sd_cmd_tx: RTL
==============

Name: sd_cmd_tx

Overview:
- Card-side transmitter for the SD CMD line in the SD card emulator.
- Serialises one 48-bit response: start bit, transmission bit, 6-bit index, 32-bit argument, CRC7 and end bit.
- Bits are driven on SD clock falling-edge strobes. The strobes come from the emulator's synchronised SD clock edge detector.
- Complements the input-side synchronisers: it owns the outgoing direction of the CMD line, including the output-enable and Ncr turnaround.

Parameters:
- NCR_MIN, 2, number of SD clock fall strobes the line stays released (Hi-Z) between accept and the start bit. Legal range 2..64.

Ports:
- clk  input  1  system clock; all logic on posedge.
- reset  input  1  synchronous, active-high reset.
- sd_clk_fall  input  1  one-cycle strobe at each synchronised SD clock falling edge.
- start  input  1  request to send a response; sampled only in IDLE.
- resp_index  input  6  command index field.
- resp_arg  input  32  argument/status field.
- resp_crc_en  input  1  1 = compute CRC7; 0 = send 7'b1111111 (R3 style).
- abort  input  1  cancel the current transfer.
- busy  output  1  high from accept until the line is released.
- done  output  1  one-cycle pulse when a response completes normally.
- cmd_o  output  1  CMD line output value.
- cmd_oe  output  1  CMD line output enable.

Behaviour:
- Reset: state IDLE, busy=0, done=0, cmd_o=1, cmd_oe=0, counters and CRC register cleared. Reset mid-transfer releases the line on the next clk edge.
- Frame order, MSB first:
  - bit47 = 0 (start)
  - bit46 = 0 (transmission bit, card to host)
  - bits45..40 = resp_index
  - bits39..8 = resp_arg
  - bits7..1 = CRC7
  - bit0 = 1 (end)
- States:
  - IDLE: start=1 latches index, arg and crc_en into a 40-bit shift register; clears the CRC; sets busy=1; goes to WAIT. start while busy is ignored and not queued.
  - WAIT: counts sd_clk_fall strobes; cmd_oe=0. When NCR_MIN strobes have been counted, the next strobe drives bit47 with cmd_oe=1; go to SHIFT.
  - SHIFT: each strobe drives the next bit. Bits 47..8 also feed a serial CRC7: polynomial x^7+x^3+1, init 0, fed with the bit being driven. Bits 7..1 come from the CRC register, or are all ones if crc_en=0. Bit 0 is 1. Bit index is held in a 6-bit down counter.
  - RELEASE: on the strobe after bit0, cmd_oe=0, cmd_o=1, busy=0; done pulses high for exactly one clk cycle; go to IDLE.
- Between strobes cmd_o and cmd_oe hold their value; outputs are registered.
- Latency: first start bit appears on the (NCR_MIN+1)th strobe after accept. Last bit is the (NCR_MIN+48)th strobe. Release happens on the (NCR_MIN+49)th strobe.
- abort in any non-IDLE state: on the next clk edge cmd_oe=0, cmd_o=1, busy=0, done stays 0, go to IDLE. abort has priority over start and over a simultaneous strobe. abort in IDLE has no effect.
- Input fields may change after accept without affecting the frame in flight.
- sd_clk_fall held high for several clocks counts once per clk cycle high; the upstream detector must produce single-cycle strobes.
- start in the same cycle as the RELEASE transition is ignored; a new request is accepted from the following IDLE cycle.

Test Plan:
- R1 vector: index=17, arg=0x00000900, crc_en=1, NCR_MIN=2, strobe every 4 clk. Required: 2 released strobes, then bit stream 0x110000090067 MSB first (CRC7=0x33), done pulse on strobe 51, cmd_oe low after.
- R3 vector: index=0x3F, arg=0x80FF8000, crc_en=0. Required: bits7..1 all ones, frame 0x3F80FF8000FF.
- Abort while bit 20 is driven: required cmd_oe=0 and busy=0 one clk later, no done pulse; next start produces a full correct frame.
- start pulsed during SHIFT with a different index: ignored; frame in flight unchanged.
- Reset asserted mid-SHIFT with cmd_o=0: required cmd_oe=0, cmd_o=1, busy=0 after one clk.
- NCR_MIN=8, irregular strobe spacing (1..7 clk): start bit on exactly the 9th strobe; no output change between strobes.

Source files
------------

// File: rtl/sd_cmd_tx.sv
// Card-side SD CMD line transmitter: serialises one 48-bit response frame
// (start, transmission, index, argument, CRC7, end) on SD clock fall strobes.
module sd_cmd_tx #(
    parameter int unsigned NCR_MIN = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sd_clk_fall,
    input  logic        start,
    input  logic [5:0]  resp_index,
    input  logic [31:0] resp_arg,
    input  logic        resp_crc_en,
    input  logic        abort,
    output logic        busy,
    output logic        done,
    output logic        cmd_o,
    output logic        cmd_oe
);

    typedef enum logic [1:0] {StIdle, StWait, StShift, StRelease} state_t;

    localparam logic [6:0] NCR_CNT = 7'(NCR_MIN);

    state_t      r_state, w_state_d;
    logic [39:0] r_shift, w_shift_d;
    logic [6:0]  r_crc, w_crc_d;
    logic        r_crc_en, w_crc_en_d;
    logic [6:0]  r_ncr_cnt, w_ncr_cnt_d;
    logic [5:0]  r_bit_cnt, w_bit_cnt_d;
    logic        r_busy, w_busy_d;
    logic        r_done, w_done_d;
    logic        r_cmd_o, w_cmd_o_d;
    logic        r_cmd_oe, w_cmd_oe_d;
    logic [5:0]  w_next_idx;

    // Serial CRC7, x^7 + x^3 + 1, fed MSB first.
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic b);
        logic fb;
        fb = b ^ crc[6];
        return {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
    endfunction

    assign w_next_idx = r_bit_cnt - 6'd1;

    always_comb begin
        w_state_d   = r_state;
        w_shift_d   = r_shift;
        w_crc_d     = r_crc;
        w_crc_en_d  = r_crc_en;
        w_ncr_cnt_d = r_ncr_cnt;
        w_bit_cnt_d = r_bit_cnt;
        w_busy_d    = r_busy;
        w_done_d    = 1'b0;
        w_cmd_o_d   = r_cmd_o;
        w_cmd_oe_d  = r_cmd_oe;

        unique case (r_state)
            StIdle: begin
                if (start) begin
                    w_shift_d   = {2'b00, resp_index, resp_arg};
                    w_crc_en_d  = resp_crc_en;
                    w_crc_d     = 7'd0;
                    w_ncr_cnt_d = 7'd0;
                    w_busy_d    = 1'b1;
                    w_state_d   = StWait;
                end
            end
            StWait: begin
                if (sd_clk_fall) begin
                    if (r_ncr_cnt == NCR_CNT) begin
                        w_cmd_o_d   = r_shift[39];
                        w_cmd_oe_d  = 1'b1;
                        w_crc_d     = crc7_step(r_crc, r_shift[39]);
                        w_shift_d   = {r_shift[38:0], 1'b0};
                        w_bit_cnt_d = 6'd47;
                        w_state_d   = StShift;
                    end else begin
                        w_ncr_cnt_d = r_ncr_cnt + 7'd1;
                    end
                end
            end
            StShift: begin
                if (sd_clk_fall) begin
                    w_bit_cnt_d = w_next_idx;
                    if (w_next_idx >= 6'd8) begin
                        w_cmd_o_d = r_shift[39];
                        w_crc_d   = crc7_step(r_crc, r_shift[39]);
                        w_shift_d = {r_shift[38:0], 1'b0};
                    end else if (w_next_idx != 6'd0) begin
                        // CRC register is drained MSB first through bit 6.
                        w_cmd_o_d = r_crc_en ? r_crc[6] : 1'b1;
                        w_crc_d   = {r_crc[5:0], 1'b0};
                    end else begin
                        w_cmd_o_d = 1'b1;
                        w_state_d = StRelease;
                    end
                end
            end
            StRelease: begin
                if (sd_clk_fall) begin
                    w_cmd_oe_d = 1'b0;
                    w_cmd_o_d  = 1'b1;
                    w_busy_d   = 1'b0;
                    w_done_d   = 1'b1;
                    w_state_d  = StIdle;
                end
            end
            default: w_state_d = StIdle;
        endcase

        if (abort && (r_state != StIdle)) begin
            w_state_d  = StIdle;
            w_cmd_oe_d = 1'b0;
            w_cmd_o_d  = 1'b1;
            w_busy_d   = 1'b0;
            w_done_d   = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= StIdle;
            r_shift   <= 40'd0;
            r_crc     <= 7'd0;
            r_crc_en  <= 1'b0;
            r_ncr_cnt <= 7'd0;
            r_bit_cnt <= 6'd0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_cmd_o   <= 1'b1;
            r_cmd_oe  <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_shift   <= w_shift_d;
            r_crc     <= w_crc_d;
            r_crc_en  <= w_crc_en_d;
            r_ncr_cnt <= w_ncr_cnt_d;
            r_bit_cnt <= w_bit_cnt_d;
            r_busy    <= w_busy_d;
            r_done    <= w_done_d;
            r_cmd_o   <= w_cmd_o_d;
            r_cmd_oe  <= w_cmd_oe_d;
        end
    end

    assign busy   = r_busy;
    assign done   = r_done;
    assign cmd_o  = r_cmd_o;
    assign cmd_oe = r_cmd_oe;

endmodule
